// File: rtl/fpdiv_pkg.sv
// Shared definitions for the fpdiv datapath.
// Exception codes, constants and operand-issue FSM states.
package fpdiv_pkg;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_UFL  = 2'b01;
    localparam logic [1:0] EXC_OFL  = 2'b10;
    localparam logic [1:0] EXC_INV  = 2'b11;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single classifier.
// Subnormals are flushed: a zero exponent means zero.
module fp_classify
    import fpdiv_pkg::*;
(
    input  logic [31:0] op,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        hidden
);

    logic [7:0]  exp_f;
    logic [22:0] frac_f;

    assign exp_f  = op[30:23];
    assign frac_f = op[22:0];

    // Decode the exponent/fraction fields into operand classes
    always_comb begin
        is_zero = (exp_f == 8'h00);
        is_inf  = (exp_f == EXP_MAX) && (frac_f == 23'd0);
        is_nan  = (exp_f == EXP_MAX) && (frac_f != 23'd0);
        hidden  = (exp_f != 8'h00);
    end

endmodule

// File: rtl/fpdiv_operand_issue.sv
// Operand front-end for the fpdiv mantissa divider.
// Resolves special operands locally, else launches and waits.
module fpdiv_operand_issue #(
    parameter int          TIMEOUT_CYCLES = 32,
    parameter logic [31:0] QNAN           = fpdiv_pkg::QNAN
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] InputA,
    input  logic [31:0] InputB,
    output logic        div_start,
    output logic [32:0] dividend,
    output logic [32:0] divisor,
    output logic [7:0]  expA,
    output logic [7:0]  expB,
    input  logic        div_done,
    input  logic [22:0] div_result,
    input  logic [7:0]  div_expo,
    input  logic [1:0]  div_except,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] AbyB,
    output logic [1:0]  EXCEPTION
);

    import fpdiv_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        in_ready_q, in_ready_d;
    logic        div_start_q, div_start_d;
    logic        out_valid_q, out_valid_d;
    logic [32:0] dividend_q, dividend_d;
    logic [32:0] divisor_q, divisor_d;
    logic [7:0]  expa_q, expa_d;
    logic [7:0]  expb_q, expb_d;
    logic [31:0] abyb_q, abyb_d;
    logic [1:0]  exc_q, exc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic zero_a, inf_a, nan_a, hid_a;
    logic zero_b, inf_b, nan_b, hid_b;
    logic sign;

    fp_classify u_cls_a (
        .op      (a_q),
        .is_zero (zero_a),
        .is_inf  (inf_a),
        .is_nan  (nan_a),
        .hidden  (hid_a)
    );

    fp_classify u_cls_b (
        .op      (b_q),
        .is_zero (zero_b),
        .is_inf  (inf_b),
        .is_nan  (nan_b),
        .hidden  (hid_b)
    );

    assign sign = a_q[31] ^ b_q[31];

    // Next-state and registered-output logic for one operation in flight
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        in_ready_d  = in_ready_q;
        div_start_d = 1'b0;
        out_valid_d = out_valid_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        expa_d      = expa_q;
        expb_d      = expb_q;
        abyb_d      = abyb_q;
        exc_d       = exc_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = InputA;
                    b_d        = InputB;
                    in_ready_d = 1'b0;
                    state_d    = CLASSIFY;
                end
            end
            CLASSIFY: begin
                if (nan_a || nan_b || (zero_a && zero_b)
                    || (inf_a && inf_b)) begin
                    abyb_d      = QNAN;
                    exc_d       = EXC_INV;
                    out_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (zero_b && !inf_a) begin
                    abyb_d      = {sign, EXP_MAX, 23'd0};
                    exc_d       = EXC_INV;
                    out_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (inf_a) begin
                    abyb_d      = {sign, EXP_MAX, 23'd0};
                    exc_d       = EXC_NONE;
                    out_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (zero_a || inf_b) begin
                    abyb_d      = {sign, 31'd0};
                    exc_d       = EXC_NONE;
                    out_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    dividend_d  = {1'b0, hid_a, a_q[22:0], 8'd0};
                    divisor_d   = {1'b0, hid_b, b_q[22:0], 8'd0};
                    expa_d      = a_q[30:23];
                    expb_d      = b_q[30:23];
                    div_start_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    abyb_d      = {sign, div_expo, div_result};
                    exc_d       = div_except;
                    out_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    abyb_d      = QNAN;
                    exc_d       = EXC_INV;
                    out_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            in_ready_q  <= 1'b1;
            div_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            expa_q      <= '0;
            expb_q      <= '0;
            abyb_q      <= '0;
            exc_q       <= EXC_NONE;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            in_ready_q  <= in_ready_d;
            div_start_q <= div_start_d;
            out_valid_q <= out_valid_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            expa_q      <= expa_d;
            expb_q      <= expb_d;
            abyb_q      <= abyb_d;
            exc_q       <= exc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign div_start = div_start_q;
    assign out_valid = out_valid_q;
    assign dividend  = dividend_q;
    assign divisor   = divisor_q;
    assign expA      = expa_q;
    assign expB      = expb_q;
    assign AbyB      = abyb_q;
    assign EXCEPTION = exc_q;

endmodule
